mips_mem_arbiter: RTL and testbench

//  Single-port memory controller/arbiter for the MIPS32 pipeline's unified Mem.

---
 rtl/mips_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter for the MIPS32 unified Mem: loader, fetch and data ports
// share one synchronous RAM port, with the system sequenced through BOOT, RUN and HALT.
module mips_mem_arbiter #(
  parameter int unsigned AW           = 10,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk1,
  input  logic          reset,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic          ld_done,
  input  logic          ld_restart,
  output logic          ld_gnt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  input  logic          cpu_halted,
  output logic          cpu_hold,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic [1:0]    rsrc
);

  localparam int unsigned    SW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  SLIM = SW'(STARVE_LIMIT);

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_IF   = 2'b01;
  localparam logic [1:0] SRC_DM   = 2'b10;
  localparam logic [1:0] SRC_LD   = 2'b11;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [DW-1:0] rdata_q;
  logic          rvalid_q, rvalid_d;
  logic [1:0]    rsrc_q, rsrc_d;
  logic [1:0]    owner;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  if (ld_done)    state_d = S_RUN;
      S_RUN:   if (cpu_halted) state_d = S_HALT;
      S_HALT:  if (ld_restart) state_d = S_BOOT;
      default: state_d = S_BOOT;
    endcase
  end

  // Grants are gated by reset directly so the RAM is never enabled while reset is high.
  always_comb begin
    ld_gnt = 1'b0;
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!reset) begin
      case (state_q)
        S_BOOT, S_HALT: ld_gnt = ld_req;
        S_RUN: begin
          if (dm_req && !(if_req && (starve_q == SLIM))) dm_gnt = 1'b1;
          else if (if_req)                                 if_gnt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner     = SRC_NONE;
    if (ld_gnt) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      owner     = SRC_LD;
    end else if (dm_gnt) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      owner     = SRC_DM;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
      owner     = SRC_IF;
    end
  end

  assign mem_en   = ld_gnt | if_gnt | dm_gnt;
  assign rvalid_d = mem_en & ~mem_we;
  assign rsrc_d   = rvalid_d ? owner : SRC_NONE;
  assign cpu_hold = (state_q == S_BOOT);

  always_comb begin
    starve_d = starve_q;
    if (dm_gnt && if_req) begin
      if (starve_q != SLIM) starve_d = starve_q + SW'(1);
    end else if (if_gnt || !if_req) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state_q  <= S_BOOT;
      starve_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rsrc_q   <= SRC_NONE;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rvalid_q <= rvalid_d;
      rsrc_q   <= rsrc_d;
      if (rvalid_q) rdata_q <= mem_rdata;
    end
  end

  // The RAM output register supplies the data in the return cycle; rdata_q keeps it afterwards.
  assign rdata  = rvalid_q ? mem_rdata : rdata_q;
  assign rvalid = rvalid_q;
  assign rsrc   = rsrc_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed boot/run/halt sequence plus randomized run traffic,
// checked against a transaction-level model with its own shadow memory.
module tb_mips_mem_arbiter;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk1 = 1'b0;
  logic          reset;
  logic          ld_req, ld_we, ld_done, ld_restart, ld_gnt;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          if_req, if_gnt;
  logic [AW-1:0] if_addr;
  logic          dm_req, dm_we, dm_gnt;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          cpu_halted, cpu_hold;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, rdata;
  logic          rvalid;
  logic [1:0]    rsrc;

  always #5 clk1 = ~clk1;

  mips_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk1(clk1), .reset(reset),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_restart(ld_restart), .ld_gnt(ld_gnt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .cpu_halted(cpu_halted), .cpu_hold(cpu_hold),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rdata(rdata), .rvalid(rvalid), .rsrc(rsrc)
  );

  // Environment RAM: synchronous single port, registered read data.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Reference model: mode 0=boot 1=run 2=halt; grant codes 0 none 1 fetch 2 data 3 loader.
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            mode, starve, last_g;
  logic          exp_rv;
  logic [1:0]    exp_src;
  logic [DW-1:0] exp_dat;
  int            tests = 0, fails = 0;
  logic [DW-1:0] prog [0:7];
  int            starve_seq [0:5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (mode == 1) begin
      if (dm_req && !(if_req && starve == LIM)) return 2;
      if (if_req) return 1;
      return 0;
    end
    return ld_req ? 3 : 0;
  endfunction

  task automatic step(input bit mid_rst);
    int            g;
    logic [AW-1:0] a;
    logic          w;
    logic [DW-1:0] wd;
    @(negedge clk1);
    g = reset ? 0 : pick();
    chk("ld_gnt", ld_gnt, g == 3);
    chk("if_gnt", if_gnt, g == 1);
    chk("dm_gnt", dm_gnt, g == 2);
    chk("mem_en", mem_en, g != 0);
    chk("cpu_hold", cpu_hold, mode == 0);
    a = '0; w = 1'b0; wd = '0;
    case (g)
      1: a = if_addr;
      2: begin a = dm_addr; w = dm_we; wd = dm_wdata; end
      3: begin a = ld_addr; w = ld_we; wd = ld_wdata; end
      default: ;
    endcase
    if (g != 0) begin
      chk("mem_we", mem_we, w);
      chk("mem_addr", mem_addr, a);
      if (w) chk("mem_wdata", mem_wdata, wd);
    end
    if (mid_rst) begin
      #2 reset = 1'b1;
      #1;
      chk("rst_ld_gnt", ld_gnt, 0);
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_dm_gnt", dm_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_hold", cpu_hold, 1);
    end
    if (reset) begin
      mode = 0; starve = 0; exp_rv = 1'b0; exp_src = 2'b00; g = 0;
    end else begin
      exp_rv  = (g != 0) && !w;
      exp_src = exp_rv ? 2'(g) : 2'b00;
      if (exp_rv) exp_dat = shadow[a];
      if (g != 0 && w) shadow[a] = wd;
      if (g == 2 && if_req)       starve = (starve < LIM) ? starve + 1 : LIM;
      else if (g == 1 || !if_req) starve = 0;
      if (mode == 0 && ld_done)         mode = 1;
      else if (mode == 1 && cpu_halted) mode = 2;
      else if (mode == 2 && ld_restart) mode = 0;
    end
    last_g = g;
    @(posedge clk1);
    #1;
    chk("rvalid", rvalid, exp_rv);
    chk("rsrc", rsrc, exp_src);
    if (exp_rv) chk("rdata", rdata, exp_dat);
  endtask

  task automatic idle();
    ld_req = 0; ld_we = 0; ld_done = 0; ld_restart = 0;
    if_req = 0; dm_req = 0; dm_we = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin ram[i] = '0; shadow[i] = '0; end
    prog[0] = 32'h28010078; prog[1] = 32'h0c000002; prog[2] = 32'h20420001;
    prog[3] = 32'h8c230078; prog[4] = 32'h00641020; prog[5] = 32'hac220079;
    prog[6] = 32'h00000000; prog[7] = 32'hfc000000;
    starve_seq[0] = 2; starve_seq[1] = 2; starve_seq[2] = 2;
    starve_seq[3] = 2; starve_seq[4] = 1; starve_seq[5] = 2;
    mode = 0; starve = 0; exp_rv = 0; exp_src = 0; exp_dat = 0; last_g = 0;
    reset = 1'b1; cpu_halted = 0;
    idle();
    ld_addr = '0; ld_wdata = '0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
    ld_req = 1; if_req = 1; dm_req = 1;

    // Reset: everything quiet, hold asserted.
    step(0);
    chk("reset_rdata", rdata, 0);
    reset = 1'b0;
    idle();

    // Boot: program load with stray fetch requests ignored.
    for (int i = 0; i < 8; i++) begin
      ld_req = 1; ld_we = 1; ld_addr = AW'(i); ld_wdata = prog[i]; if_req = 1;
      step(0);
    end
    ld_addr = 120; ld_wdata = 85; step(0);
    ld_we = 0; ld_addr = 0; step(0);
    idle(); ld_done = 1; step(0);
    ld_done = 0; step(0);
    chk("run_hold", cpu_hold, 0);

    // Back-to-back fetches.
    for (int i = 0; i < 4; i++) begin
      if_req = 1; if_addr = AW'(i); step(0);
    end
    idle();

    // Contention: data beats fetch, fetch goes once data drops.
    if_req = 1; if_addr = 4; dm_req = 1; dm_we = 0; dm_addr = 120; step(0);
    dm_req = 0; step(0);
    idle(); step(0);

    // Starvation: both held for six cycles.
    if_req = 1; if_addr = 5; dm_req = 1; dm_we = 0; dm_addr = 120;
    for (int k = 0; k < 6; k++) begin
      step(0);
      chk("starve_seq", 32'(last_g), 32'(starve_seq[k]));
    end
    idle(); step(0);

    // Randomized run traffic; ungranted requesters keep their request.
    for (int n = 0; n < 300; n++) begin
      if (!(if_req && last_g != 1)) begin
        if_req = 1'($urandom % 2); if_addr = AW'($urandom_range(0, 63));
      end
      if (!(dm_req && last_g != 2)) begin
        dm_req = 1'($urandom % 2); dm_we = 1'($urandom % 2);
        dm_addr  = dm_we ? AW'($urandom_range(16, 63)) : AW'($urandom_range(0, 63));
        dm_wdata = $urandom;
      end
      ld_req = 1'($urandom % 2); ld_we = 1'($urandom % 2); ld_addr = AW'($urandom_range(0, 63));
      step(0);
    end
    idle(); step(0);

    // Write then read the same address in consecutive cycles.
    dm_req = 1; dm_we = 1; dm_addr = 121; dm_wdata = 130; step(0);
    dm_we = 0; step(0);
    idle(); step(0);

    // Halt in a cycle with a pending read, then loader readback.
    cpu_halted = 1; dm_req = 1; dm_we = 0; dm_addr = 120; if_req = 1; if_addr = 6;
    step(0);
    ld_req = 1; ld_we = 0; ld_addr = 121; step(0);
    ld_req = 0; step(0);
    chk("halt_readback", rdata, 130);
    idle(); ld_restart = 1; step(0);
    ld_restart = 0; cpu_halted = 0; step(0);
    chk("boot_hold", cpu_hold, 1);

    // Reset while a loader read is in flight.
    ld_req = 1; ld_we = 0; ld_addr = 120; step(1);
    chk("midrst_hold", cpu_hold, 1);
    reset = 1'b0; idle(); step(0);

    // Back to run after the reset and fetch once.
    ld_done = 1; step(0);
    ld_done = 0; if_req = 1; if_addr = 0; step(0);
    idle(); step(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
